// File: rtl/mips_dec_pkg.sv
// Shared encodings for the MIPS decode stage: opcode/funct values, class indices
// and the decoded-instruction record passed between the decoder and the stage.
package mips_dec_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam int CLS_ORI   = 0;
  localparam int CLS_LUI   = 1;
  localparam int CLS_LW    = 2;
  localparam int CLS_SW    = 3;
  localparam int CLS_BEQ   = 4;
  localparam int CLS_JAL   = 5;
  localparam int CLS_ADDU  = 6;
  localparam int CLS_SUBU  = 7;
  localparam int CLS_JR    = 8;
  localparam int CLS_ADDIU = 9;
  localparam int CLS_J     = 10;
  localparam int CLS_SLT   = 11;
  localparam int CLS_SLL   = 12;
  localparam int CLS_JALR  = 13;
  localparam int CLS_NOP   = 14;
  localparam int NCLS      = 15;

  typedef struct packed {
    logic [NCLS-1:0] cls;
    logic [4:0]      wr_reg;
    logic            we;
    logic            illegal;
    logic            uses_rs;
    logic            uses_rt;
  } dec_t;

endpackage

// File: rtl/mips_decode_stage_if.sv
// Fetch-side and execute-side handshake/bundle signals of the decode stage.
interface mips_decode_stage_if #(
  parameter int PC_W = 32
);
  import mips_dec_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [NCLS-1:0] out_cls;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [15:0]     out_imm16;
  logic [4:0]      out_wr_reg;
  logic            out_we;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_cls, out_rs, out_rt, out_rd,
           out_imm16, out_wr_reg, out_we, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_cls, out_rs, out_rt, out_rd,
           out_imm16, out_wr_reg, out_we, out_illegal
  );
endinterface

// File: rtl/mips_decode_comb.sv
// Purely combinational instruction decoder: class, destination, write enable,
// legality and which source register fields the instruction actually reads.
module mips_decode_comb
  import mips_dec_pkg::*;
#(
  parameter bit EXT_EN = 1'b1
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op_s;
  logic [5:0] fn_s;
  logic [4:0] rt_s;
  logic [4:0] rd_s;

  assign op_s = instr[31:26];
  assign fn_s = instr[5:0];
  assign rt_s = instr[20:16];
  assign rd_s = instr[15:11];

  // Opcode/funct decode; anything unmatched falls through as illegal with no side effects.
  always_comb begin
    dec         = '0;
    dec.illegal = 1'b1;
    if (instr == 32'h0000_0000) begin
      dec.cls[CLS_NOP] = 1'b1;
      dec.illegal      = 1'b0;
    end else begin
      case (op_s)
        OP_ORI: begin
          dec.cls[CLS_ORI] = 1'b1; dec.wr_reg = rt_s; dec.uses_rs = 1'b1; dec.illegal = 1'b0;
        end
        OP_LUI: begin
          dec.cls[CLS_LUI] = 1'b1; dec.wr_reg = rt_s; dec.illegal = 1'b0;
        end
        OP_LW: begin
          dec.cls[CLS_LW] = 1'b1; dec.wr_reg = rt_s; dec.uses_rs = 1'b1; dec.illegal = 1'b0;
        end
        OP_SW: begin
          dec.cls[CLS_SW] = 1'b1; dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.illegal = 1'b0;
        end
        OP_BEQ: begin
          dec.cls[CLS_BEQ] = 1'b1; dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.illegal = 1'b0;
        end
        OP_JAL: begin
          dec.cls[CLS_JAL] = 1'b1; dec.wr_reg = 5'd31; dec.illegal = 1'b0;
        end
        OP_ADDIU: begin
          if (EXT_EN) begin
            dec.cls[CLS_ADDIU] = 1'b1; dec.wr_reg = rt_s; dec.uses_rs = 1'b1; dec.illegal = 1'b0;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OP_J: begin
          if (EXT_EN) begin
            dec.cls[CLS_J] = 1'b1; dec.illegal = 1'b0;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OP_RTYPE: begin
          case (fn_s)
            FN_ADDU: begin
              dec.cls[CLS_ADDU] = 1'b1; dec.wr_reg = rd_s;
              dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.illegal = 1'b0;
            end
            FN_SUBU: begin
              dec.cls[CLS_SUBU] = 1'b1; dec.wr_reg = rd_s;
              dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.illegal = 1'b0;
            end
            FN_JR: begin
              dec.cls[CLS_JR] = 1'b1; dec.uses_rs = 1'b1; dec.illegal = 1'b0;
            end
            FN_SLT: begin
              if (EXT_EN) begin
                dec.cls[CLS_SLT] = 1'b1; dec.wr_reg = rd_s;
                dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.illegal = 1'b0;
              end else begin
                dec.illegal = 1'b1;
              end
            end
            FN_SLL: begin
              if (EXT_EN) begin
                dec.cls[CLS_SLL] = 1'b1; dec.wr_reg = rd_s; dec.uses_rt = 1'b1; dec.illegal = 1'b0;
              end else begin
                dec.illegal = 1'b1;
              end
            end
            FN_JALR: begin
              if (EXT_EN) begin
                dec.cls[CLS_JALR] = 1'b1; dec.wr_reg = rd_s; dec.uses_rs = 1'b1; dec.illegal = 1'b0;
              end else begin
                dec.illegal = 1'b1;
              end
            end
            default: dec.illegal = 1'b1;
          endcase
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    dec.we = !dec.illegal && (dec.wr_reg != 5'd0);
  end

endmodule

// File: rtl/mips_decode_stage.sv
// Registered MIPS decode stage: valid/ready pipeline register around the decoder,
// one-bubble load-use interlock and saturating performance counters.
module mips_decode_stage
  import mips_dec_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 16,
  parameter bit EXT_EN      = 1'b1,
  parameter bit LOAD_USE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  mips_decode_stage_if.slave bus,
  output logic [CNT_W-1:0] cnt_instr,
  output logic [CNT_W-1:0] cnt_bubble,
  output logic [CNT_W-1:0] cnt_illegal
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  dec_t            dec_in_s;
  logic            hazard_s;
  logic            in_ready_s;
  logic            xfer_in_s;
  logic            xfer_out_s;

  logic            out_valid_r;
  logic [PC_W-1:0] pc_r;
  logic [25:0]     fields_r;
  logic [NCLS-1:0] cls_r;
  logic [4:0]      wr_r;
  logic            we_r;
  logic            ill_r;
  logic [CNT_W-1:0] cnt_instr_r;
  logic [CNT_W-1:0] cnt_bubble_r;
  logic [CNT_W-1:0] cnt_illegal_r;

  mips_decode_comb #(.EXT_EN(EXT_EN)) u_dec (
    .instr (bus.in_instr),
    .dec   (dec_in_s)
  );

  // Load-use check only looks at the held bundle, so a dependent op waits exactly one cycle.
  always_comb begin
    hazard_s = 1'b0;
    if (LOAD_USE_EN && out_valid_r && cls_r[CLS_LW] && (wr_r != 5'd0) && bus.in_valid) begin
      hazard_s = (dec_in_s.uses_rs && (bus.in_instr[25:21] == wr_r)) ||
                 (dec_in_s.uses_rt && (bus.in_instr[20:16] == wr_r));
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Handshake qualifiers; a flushed cycle neither accepts nor retires.
  always_comb begin
    in_ready_s = rst_n && !flush && (!out_valid_r || bus.out_ready) && !hazard_s;
    xfer_in_s  = bus.in_valid && in_ready_s;
    xfer_out_s = out_valid_r && bus.out_ready && !flush;
  end

  // Output pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      pc_r        <= '0;
      fields_r    <= 26'd0;
      cls_r       <= '0;
      wr_r        <= 5'd0;
      we_r        <= 1'b0;
      ill_r       <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (xfer_in_s) begin
      out_valid_r <= 1'b1;
      pc_r        <= bus.in_pc;
      fields_r    <= bus.in_instr[25:0];
      cls_r       <= dec_in_s.cls;
      wr_r        <= dec_in_s.wr_reg;
      we_r        <= dec_in_s.we;
      ill_r       <= dec_in_s.illegal;
    end else if (xfer_out_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_instr_r   <= '0;
      cnt_bubble_r  <= '0;
      cnt_illegal_r <= '0;
    end else begin
      if (xfer_out_s && (cnt_instr_r != CNT_MAX)) begin
        cnt_instr_r <= cnt_instr_r + CNT_ONE;
      end
      if (xfer_out_s && ill_r && (cnt_illegal_r != CNT_MAX)) begin
        cnt_illegal_r <= cnt_illegal_r + CNT_ONE;
      end
      if (hazard_s && !flush && (cnt_bubble_r != CNT_MAX)) begin
        cnt_bubble_r <= cnt_bubble_r + CNT_ONE;
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_pc      = pc_r;
  assign bus.out_cls     = cls_r;
  assign bus.out_rs      = fields_r[25:21];
  assign bus.out_rt      = fields_r[20:16];
  assign bus.out_rd      = fields_r[15:11];
  assign bus.out_imm16   = fields_r[15:0];
  assign bus.out_wr_reg  = wr_r;
  assign bus.out_we      = we_r;
  assign bus.out_illegal = ill_r;
  assign cnt_instr       = cnt_instr_r;
  assign cnt_bubble      = cnt_bubble_r;
  assign cnt_illegal     = cnt_illegal_r;

endmodule
